// File: rtl/hd_program_loader.sv
// Copy engine that streams a program image from HardDisk sectors into MemoryInstructions.
// One start command copies `length` words; range errors are flagged before any write.
module hd_program_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int TRACK_W  = 10,
    parameter int SECTOR_W = 4,
    parameter int HD_LAT   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [TRACK_W-1:0]  src_track,
    input  logic [SECTOR_W-1:0] src_sector,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    output logic [TRACK_W-1:0]  hd_track,
    output logic [SECTOR_W-1:0] hd_sector,
    input  logic [DATA_W-1:0]   hd_data,
    output logic                mi_we,
    output logic [ADDR_W-1:0]   mi_addr,
    output logic [DATA_W-1:0]   mi_data,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [2:0]          dbg_state
);

    // Handshake: start is a single-cycle request accepted only in IDLE with abort low;
    // done is a single-cycle acknowledge; abort is a level that wins over everything.

    localparam int LIN_W     = TRACK_W + SECTOR_W;
    localparam int SUM_W     = ((LIN_W > ADDR_W + 1) ? LIN_W : ADDR_W + 1) + 1;
    localparam int DST_SUM_W = ADDR_W + 2;

    localparam logic [2:0]        LAT_LAST = 3'(HD_LAT - 1);
    localparam logic [2:0]        LAT_ONE  = 3'd1;
    localparam logic [LIN_W-1:0]  LIN_ONE  = LIN_W'(1);
    localparam logic [ADDR_W-1:0] DST_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    localparam logic [DST_SUM_W-1:0] DST_LIMIT = DST_SUM_W'(1) << ADDR_W;
    localparam logic [SUM_W-1:0]     SRC_LIMIT = SUM_W'(1) << LIN_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LIN_W-1:0]    src_lin_q, src_lin_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [2:0]          lat_q, lat_d;
    logic [ADDR_W-1:0]   mi_addr_q, mi_addr_d;
    logic [DATA_W-1:0]   mi_data_q, mi_data_d;
    logic                error_q, error_d;
    logic                mi_we_c;

    logic [DST_SUM_W-1:0] dst_end;
    logic [SUM_W-1:0]     src_end;

    assign dst_end = DST_SUM_W'(dst_q) + DST_SUM_W'(rem_q);
    assign src_end = SUM_W'(src_lin_q) + SUM_W'(rem_q);

    always_comb begin
        state_d   = state_q;
        src_lin_d = src_lin_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        lat_d     = lat_q;
        mi_addr_d = mi_addr_q;
        mi_data_d = mi_data_q;
        error_d   = error_q;
        mi_we_c   = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        src_lin_d = {src_track, src_sector};
                        dst_d     = dst_addr;
                        rem_d     = length;
                        error_d   = 1'b0;
                        state_d   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    lat_d = '0;
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else if (dst_end > DST_LIMIT) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (src_end > SRC_LIMIT) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Address has been stable for HD_LAT cycles on the last one, so data is valid.
                    if (lat_q == LAT_LAST) begin
                        mi_data_d = hd_data;
                        mi_addr_d = dst_q;
                        lat_d     = '0;
                        state_d   = S_WRITE;
                    end else begin
                        lat_d = lat_q + LAT_ONE;
                    end
                end
                S_WRITE: begin
                    mi_we_c   = 1'b1;
                    src_lin_d = src_lin_q + LIN_ONE;
                    dst_d     = dst_q + DST_ONE;
                    rem_d     = rem_q - REM_ONE;
                    state_d   = (rem_q == REM_ONE) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            src_lin_q <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            lat_q     <= '0;
            mi_addr_q <= '0;
            mi_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_lin_q <= src_lin_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            lat_q     <= lat_d;
            mi_addr_q <= mi_addr_d;
            mi_data_q <= mi_data_d;
            error_q   <= error_d;
        end
    end

    // The linear source address splits directly into track and sector fields.
    assign hd_track  = src_lin_q[LIN_W-1:SECTOR_W];
    assign hd_sector = src_lin_q[SECTOR_W-1:0];
    assign mi_we     = mi_we_c & ~reset;
    assign mi_addr   = mi_addr_q;
    assign mi_data   = mi_data_q;
    assign busy      = (state_q == S_CHECK) || (state_q == S_FETCH) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE) && !abort;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Bench for hd_program_loader: one instance at HD read latency 1, one at latency 3,
// a combinational disk model, and a write scoreboard per instance.
module tb_hd_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hd_word(input logic [9:0] t, input logic [3:0] s);
        return {8'hC3, 6'd0, t, 4'd0, s};
    endfunction

    // ---------------- instance with HD_LAT = 1 ----------------
    logic        rst1, start1, abort1;
    logic [9:0]  trk1;
    logic [3:0]  sec1;
    logic [11:0] dst1;
    logic [12:0] len1;
    logic [9:0]  hd_track1;
    logic [3:0]  hd_sector1;
    logic [31:0] hd_data1;
    logic        mi_we1, busy1, done1, error1;
    logic [11:0] mi_addr1;
    logic [31:0] mi_data1;
    logic [2:0]  dbg1;

    assign hd_data1 = hd_word(hd_track1, hd_sector1);

    hd_program_loader #(.HD_LAT(1)) u_dut1 (
        .clock(clk), .reset(rst1), .start(start1), .abort(abort1),
        .src_track(trk1), .src_sector(sec1), .dst_addr(dst1), .length(len1),
        .hd_track(hd_track1), .hd_sector(hd_sector1), .hd_data(hd_data1),
        .mi_we(mi_we1), .mi_addr(mi_addr1), .mi_data(mi_data1),
        .busy(busy1), .done(done1), .error(error1), .dbg_state(dbg1)
    );

    // ---------------- instance with HD_LAT = 3 ----------------
    logic        rst3, start3, abort3;
    logic [9:0]  trk3;
    logic [3:0]  sec3;
    logic [11:0] dst3;
    logic [12:0] len3;
    logic [9:0]  hd_track3;
    logic [3:0]  hd_sector3;
    logic [31:0] hd_data3;
    logic        mi_we3, busy3, done3, error3;
    logic [11:0] mi_addr3;
    logic [31:0] mi_data3;
    logic [2:0]  dbg3;

    assign hd_data3 = hd_word(hd_track3, hd_sector3);

    hd_program_loader #(.HD_LAT(3)) u_dut3 (
        .clock(clk), .reset(rst3), .start(start3), .abort(abort3),
        .src_track(trk3), .src_sector(sec3), .dst_addr(dst3), .length(len3),
        .hd_track(hd_track3), .hd_sector(hd_sector3), .hd_data(hd_data3),
        .mi_we(mi_we3), .mi_addr(mi_addr3), .mi_data(mi_data3),
        .busy(busy3), .done(done3), .error(error3), .dbg_state(dbg3)
    );

    // ---------------- scoreboards: {addr, data} per expected write ----------------
    logic [43:0] exp_q1[$];
    logic [43:0] exp_q3[$];
    int          we_cyc_q1[$];
    int          we_cnt1 = 0;
    int          we_cnt3 = 0;

    always @(negedge clk) begin
        if (mi_we1) begin
            we_cnt1++;
            we_cyc_q1.push_back(cyc);
            check("sb1_expected_write", 64'(exp_q1.size() != 0), 64'd1);
            if (exp_q1.size() != 0) check("sb1_write", {mi_addr1, mi_data1}, exp_q1.pop_front());
        end
        if (mi_we3) begin
            we_cnt3++;
            check("sb3_expected_write", 64'(exp_q3.size() != 0), 64'd1);
            if (exp_q3.size() != 0) check("sb3_write", {mi_addr3, mi_data3}, exp_q3.pop_front());
        end
    end

    task automatic push_words1(input logic [9:0] t, input logic [3:0] s,
                               input logic [11:0] d, input int n);
        logic [13:0] lin;
        logic [11:0] a;
        lin = {t, s};
        a   = d;
        for (int i = 0; i < n; i++) begin
            exp_q1.push_back({a, hd_word(lin[13:4], lin[3:0])});
            lin = lin + 14'd1;
            a   = a + 12'd1;
        end
    endtask

    task automatic start1_drive(input logic [9:0] t, input logic [3:0] s,
                                input logic [11:0] d, input logic [12:0] l, output int st);
        @(posedge clk); #1;
        trk1 = t; sec1 = s; dst1 = d; len1 = l; start1 = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        check("busy_in_check", 64'(busy1), 64'd1);
    endtask

    task automatic wait_done1(output int dcyc);
        int n;
        dcyc = -1;
        n = 0;
        while (dcyc < 0 && n < 200) begin
            @(negedge clk);
            if (done1) dcyc = cyc;
            n++;
        end
        check("done_seen", 64'(dcyc >= 0), 64'd1);
    endtask

    task automatic run1(input string tag, input logic [9:0] t, input logic [3:0] s,
                        input logic [11:0] d, input logic [12:0] l, input bit exp_err);
        int st, dc, nwr, exp_lat;
        nwr = exp_err ? 0 : int'(l);
        exp_lat = (nwr == 0) ? 2 : 2 + 2 * nwr;
        we_cnt1 = 0;
        we_cyc_q1.delete();
        push_words1(t, s, d, nwr);
        start1_drive(t, s, d, l, st);
        wait_done1(dc);
        check({tag, "_done_latency"}, 64'(dc - st), 64'(exp_lat));
        check({tag, "_busy_at_done"}, 64'(busy1), 64'd0);
        check({tag, "_write_count"}, 64'(we_cnt1), 64'(nwr));
        check({tag, "_sb_empty"}, 64'(exp_q1.size()), 64'd0);
        check({tag, "_error"}, 64'(error1), 64'(exp_err));
        if (we_cyc_q1.size() != 0) check({tag, "_first_write"}, 64'(we_cyc_q1[0] - st), 64'd3);
        for (int i = 1; i < we_cyc_q1.size(); i++)
            check({tag, "_write_gap"}, 64'(we_cyc_q1[i] - we_cyc_q1[i-1]), 64'd2);
        exp_q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, dn;
        rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; trk1 = '0; sec1 = '0; dst1 = '0; len1 = '0;
        rst3 = 1'b1; start3 = 1'b0; abort3 = 1'b0; trk3 = '0; sec3 = '0; dst3 = '0; len3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst1_outputs", {hd_track1, hd_sector1, mi_we1, mi_addr1, mi_data1, busy1, done1, error1}, 64'd0);
        check("rst1_state", 64'(dbg1), 64'd0);
        check("rst3_outputs", {hd_track3, hd_sector3, mi_we3, mi_addr3, mi_data3, busy3, done3, error3}, 64'd0);
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0;

        // Main copy across a track boundary, then length 0, range errors and fits at the edges.
        run1("copy4",     10'd2,    4'd14, 12'h010, 13'd4, 1'b0);
        run1("len0",      10'd4,    4'd0,  12'h100, 13'd0, 1'b0);
        run1("dst_range", 10'd0,    4'd0,  12'hFFE, 13'd3, 1'b1);
        run1("clear_err", 10'd0,    4'd0,  12'h020, 13'd1, 1'b0);
        run1("dst_fit",   10'd0,    4'd3,  12'hFFC, 13'd4, 1'b0);
        run1("src_range", 10'd1023, 4'd15, 12'h000, 13'd2, 1'b1);
        run1("src_fit",   10'd1023, 4'd15, 12'h200, 13'd1, 1'b0);
        run1("random",    10'($urandom_range(0, 900)), 4'($urandom_range(0, 15)),
             12'($urandom_range(0, 3000)), 13'($urandom_range(1, 6)), 1'b0);

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1;
        trk1 = 10'd1; sec1 = 4'd0; dst1 = 12'h050; len1 = 13'd2; start1 = 1'b1; abort1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; abort1 = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", 64'(busy1), 64'd0);
        check("start_abort_idle_state", 64'(dbg1), 64'd0);

        // Abort in the second FETCH of a 5-word copy, with an ignored start issued while busy.
        we_cnt1 = 0;
        we_cyc_q1.delete();
        push_words1(10'd5, 4'd0, 12'h300, 1);
        start1_drive(10'd5, 4'd0, 12'h300, 13'd5, st);
        @(posedge clk); #1;
        trk1 = 10'd9; dst1 = 12'h700; len1 = 13'd1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        abort1 = 1'b1;
        @(negedge clk);
        check("abort_busy_during", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        abort1 = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 64'(busy1), 64'd0);
        check("abort_state_idle", 64'(dbg1), 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        check("abort_write_count", 64'(we_cnt1), 64'd1);
        check("abort_sb_empty", 64'(exp_q1.size()), 64'd0);

        // HD_LAT = 3: address held through each FETCH, 4-clock word period.
        we_cnt3 = 0;
        exp_q3.push_back({12'h040, hd_word(10'd7, 4'd15)});
        exp_q3.push_back({12'h041, hd_word(10'd8, 4'd0)});
        @(posedge clk); #1;
        trk3 = 10'd7; sec3 = 4'd15; dst3 = 12'h040; len3 = 13'd2; start3 = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (k >= 2 && k <= 4) check("lat3_addr_w0", {hd_track3, hd_sector3}, {10'd7, 4'd15});
            if (k >= 6 && k <= 8) check("lat3_addr_w1", {hd_track3, hd_sector3}, {10'd8, 4'd0});
            check("lat3_we", 64'(mi_we3), 64'(k == 5 || k == 9));
            check("lat3_busy", 64'(busy3), 64'(k <= 9));
            check("lat3_done", 64'(done3), 64'(k == 10));
        end
        check("lat3_write_count", 64'(we_cnt3), 64'd2);
        check("lat3_sb_empty", 64'(exp_q3.size()), 64'd0);

        // HD_LAT = 3 with reset during the second word's FETCH.
        we_cnt3 = 0;
        exp_q3.push_back({12'h080, hd_word(10'd3, 4'd4)});
        @(posedge clk); #1;
        trk3 = 10'd3; sec3 = 4'd4; dst3 = 12'h080; len3 = 13'd2; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {hd_track3, hd_sector3, mi_we3, mi_addr3, mi_data3, busy3, done3, error3}, 64'd0);
        check("rst_mid_state", 64'(dbg3), 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done3) dn++;
        end
        check("rst_mid_no_done", 64'(dn), 64'd0);
        check("rst_mid_write_count", 64'(we_cnt3), 64'd1);
        check("rst_mid_sb_empty", 64'(exp_q3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
